instruction_decoder: RTL
========================

// Module: instruction_decoder
// PURPOSE
// - Per-core decoder; the producing end of the ALU control interface. Registers
//   one 16-bit instruction in DECODE and drives the ALU muxes, register-file,
//   LSU, NZP/PC control and a few status outputs.
// - Outputs hold stable from the cycle after DECODE until the next DECODE, for
//   use by the ALU in EXECUTE and the PC/regfile in UPDATE.
// PARAMETERS
// - CNT_WIDTH  16  width of decode_count (saturating count of decoded instrs)
// PORTS
// - clk                            in   1   clock
// - reset                          in   1   sync active-high reset
// - core_state                     in   3   IDLE0 FETCH1 DECODE2 REQUEST3 WAIT4 EXECUTE5 UPDATE6 DONE7
// - instruction                    in   16  [15:12]op [11:8]rd [7:4]rs [3:0]rt [11:9]nzp [7:0]imm
// - decoded_rd/rs/rt_address       out  4   register addresses
// - decoded_nzp                    out  3   branch condition mask
// - decoded_immediate              out  8   imm / branch target
// - decoded_reg_write_enable       out  1   write rd in UPDATE
// - decoded_mem_read_enable        out  1   LDR
// - decoded_mem_write_enable       out  1   STR
// - decoded_nzp_write_enable       out  1   CMP updates NZP
// - decoded_reg_input_mux          out  2   00 ALU, 01 memory, 10 immediate
// - decoded_alu_arithmetic_mux     out  2   00 ADD, 01 SUB, 10 MUL, 11 DIV
// - decoded_alu_output_mux         out  1   1 = compare result {5'b0,lt,eq,gt}
// - decoded_pc_mux                 out  1   1 = BRnzp
// - decoded_ret                    out  1   RET; thread done
// - decoded_illegal                out  1   sticky: undefined opcode seen
// - decode_count                   out  CNT_WIDTH  saturating decode counter
// BEHAVIOUR
// - Reset: every output 0. Reset beats DECODE in the same cycle.
// - Capture only on posedge clk with core_state==3'b010; outputs valid from next cycle.
// - All other states: every output holds; instruction is ignored.
// - On each DECODE, all enables, muxes, pc_mux, ret clear to 0, then set per opcode.
//   Address/nzp/imm fields always copy instruction bits, whatever the opcode.
// - Opcode map (all unlisted controls 0):
//   0000 NOP   nothing
//   0001 BRnzp pc_mux=1
//   0010 CMP   alu_output_mux=1, nzp_write_enable=1
//   0011 ADD   reg_write=1, input_mux=00, arith=00
//   0100 SUB   reg_write=1, input_mux=00, arith=01
//   0101 MUL   reg_write=1, input_mux=00, arith=10
//   0110 DIV   reg_write=1, input_mux=00, arith=11
//   0111 LDR   reg_write=1, mem_read=1, input_mux=01
//   1000 STR   mem_write=1
//   1001 CONST reg_write=1, input_mux=10
//   1111 RET   ret=1
//   1010-1110 undefined: decode as NOP, set decoded_illegal=1.
// - decoded_illegal stays 1 until reset; a later valid opcode does not clear it.
// - decode_count +1 per DECODE cycle (incl. NOP/illegal); saturates at all-ones.
// - DECODE held several cycles: re-decode and count every cycle (core FSM holds it 1 cycle).
// - Reset mid-program: outputs and count return to 0; next DECODE proceeds normally.
// TESTING
// - reset; DECODE 16'h3123 -> next cycle rd=1 rs=2 rt=3, reg_write=1, arith=00, input_mux=00, count=1
// - DECODE 16'h2045 then core_state=EXECUTE with instruction=16'h3FFF -> alu_output_mux=1,
//   nzp_write=1, reg_write=0; outputs unchanged in EXECUTE
// - DECODE 16'h1A07 -> pc_mux=1, nzp=3'b101, imm=8'h07; then 16'h9312 -> input_mux=10, pc_mux=0
// - DECODE 16'hB000 -> all controls 0, illegal=1; then 16'h6123 -> arith=11, illegal still 1
// - CNT_WIDTH=2, 5 DECODE cycles -> decode_count 1,2,3,3,3; reset -> 0
// - reset asserted together with DECODE 16'hF000 -> decoded_ret=0, count=0

Source files
------------

// File: rtl/instruction_decoder.sv
// Per-core instruction decoder: captures one 16-bit instruction while the core is in DECODE
// and holds ALU/regfile/LSU/PC control outputs stable until the next DECODE.
module instruction_decoder #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [2:0]           core_state,
   input  logic [15:0]          instruction,
   output logic [3:0]           decoded_rd_address,
   output logic [3:0]           decoded_rs_address,
   output logic [3:0]           decoded_rt_address,
   output logic [2:0]           decoded_nzp,
   output logic [7:0]           decoded_immediate,
   output logic                 decoded_reg_write_enable,
   output logic                 decoded_mem_read_enable,
   output logic                 decoded_mem_write_enable,
   output logic                 decoded_nzp_write_enable,
   output logic [1:0]           decoded_reg_input_mux,
   output logic [1:0]           decoded_alu_arithmetic_mux,
   output logic                 decoded_alu_output_mux,
   output logic                 decoded_pc_mux,
   output logic                 decoded_ret,
   output logic                 decoded_illegal,
   output logic [CNT_WIDTH-1:0] decode_count
);

   localparam logic [2:0] ST_DECODE = 3'b010;

   logic [3:0]           rd_q, rs_q, rt_q, rd_d, rs_d, rt_d;
   logic [2:0]           nzp_q, nzp_d;
   logic [7:0]           imm_q, imm_d;
   logic                 reg_we_q, reg_we_d, mem_re_q, mem_re_d, mem_we_q, mem_we_d;
   logic                 nzp_we_q, nzp_we_d, alu_out_q, alu_out_d, pc_mux_q, pc_mux_d;
   logic                 ret_q, ret_d, illegal_q, illegal_d;
   logic [1:0]           in_mux_q, in_mux_d, arith_q, arith_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;

   // Next-state decode of the presented instruction; only committed in DECODE.
   always_comb begin
      rd_d      = instruction[11:8];
      rs_d      = instruction[7:4];
      rt_d      = instruction[3:0];
      nzp_d     = instruction[11:9];
      imm_d     = instruction[7:0];
      reg_we_d  = 1'b0;
      mem_re_d  = 1'b0;
      mem_we_d  = 1'b0;
      nzp_we_d  = 1'b0;
      in_mux_d  = 2'b00;
      arith_d   = 2'b00;
      alu_out_d = 1'b0;
      pc_mux_d  = 1'b0;
      ret_d     = 1'b0;
      illegal_d = illegal_q;
      count_d   = (count_q == {CNT_WIDTH{1'b1}}) ? count_q : count_q + CNT_WIDTH'(1);
      unique case (instruction[15:12])
         4'b0000: ;
         4'b0001: pc_mux_d = 1'b1;
         4'b0010: begin alu_out_d = 1'b1; nzp_we_d = 1'b1; end
         4'b0011: begin reg_we_d = 1'b1; arith_d = 2'b00; end
         4'b0100: begin reg_we_d = 1'b1; arith_d = 2'b01; end
         4'b0101: begin reg_we_d = 1'b1; arith_d = 2'b10; end
         4'b0110: begin reg_we_d = 1'b1; arith_d = 2'b11; end
         4'b0111: begin reg_we_d = 1'b1; mem_re_d = 1'b1; in_mux_d = 2'b01; end
         4'b1000: mem_we_d = 1'b1;
         4'b1001: begin reg_we_d = 1'b1; in_mux_d = 2'b10; end
         4'b1111: ret_d = 1'b1;
         default: illegal_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_q      <= '0;
         rs_q      <= '0;
         rt_q      <= '0;
         nzp_q     <= '0;
         imm_q     <= '0;
         reg_we_q  <= 1'b0;
         mem_re_q  <= 1'b0;
         mem_we_q  <= 1'b0;
         nzp_we_q  <= 1'b0;
         in_mux_q  <= '0;
         arith_q   <= '0;
         alu_out_q <= 1'b0;
         pc_mux_q  <= 1'b0;
         ret_q     <= 1'b0;
         illegal_q <= 1'b0;
         count_q   <= '0;
      end else if (core_state == ST_DECODE) begin
         rd_q      <= rd_d;
         rs_q      <= rs_d;
         rt_q      <= rt_d;
         nzp_q     <= nzp_d;
         imm_q     <= imm_d;
         reg_we_q  <= reg_we_d;
         mem_re_q  <= mem_re_d;
         mem_we_q  <= mem_we_d;
         nzp_we_q  <= nzp_we_d;
         in_mux_q  <= in_mux_d;
         arith_q   <= arith_d;
         alu_out_q <= alu_out_d;
         pc_mux_q  <= pc_mux_d;
         ret_q     <= ret_d;
         illegal_q <= illegal_d;
         count_q   <= count_d;
      end
   end

   assign decoded_rd_address         = rd_q;
   assign decoded_rs_address         = rs_q;
   assign decoded_rt_address         = rt_q;
   assign decoded_nzp                = nzp_q;
   assign decoded_immediate          = imm_q;
   assign decoded_reg_write_enable   = reg_we_q;
   assign decoded_mem_read_enable    = mem_re_q;
   assign decoded_mem_write_enable   = mem_we_q;
   assign decoded_nzp_write_enable   = nzp_we_q;
   assign decoded_reg_input_mux      = in_mux_q;
   assign decoded_alu_arithmetic_mux = arith_q;
   assign decoded_alu_output_mux     = alu_out_q;
   assign decoded_pc_mux             = pc_mux_q;
   assign decoded_ret                = ret_q;
   assign decoded_illegal            = illegal_q;
   assign decode_count               = count_q;

endmodule
